iter_div_unit: RTL and testbench



---
 rtl/iter_div_unit_pkg.sv | 34 +++
 rtl/div_iter_step.sv | 19 +
 rtl/iter_div_unit.sv | 140 ++++++++++++++
 tb/tb_iter_div_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iter_div_unit_pkg.sv
// Shared types and sizing helpers for the iterative divide unit.
package iter_div_unit_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_MOD  = 2'd1,
        OP_DIVU = 2'd2,
        OP_MODU = 2'd3
    } div_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

    function automatic int div_iters(input int xlen, input int radix_bits);
        return xlen / radix_bits;
    endfunction

    function automatic int div_cnt_w(input int xlen, input int radix_bits);
        return $clog2(xlen / radix_bits);
    endfunction

    function automatic logic op_is_rem(input div_op_t op);
        return (op == OP_MOD) || (op == OP_MODU);
    endfunction

    function automatic logic op_is_signed(input div_op_t op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring division step: subtract divisor from the shifted partial
// remainder if it fits, emitting the quotient bit.
module div_iter_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] div_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_o
);

    logic [XLEN:0] diff;

    // rem_i < 2*div_i always holds, so the borrow out of bit XLEN decides.
    assign diff  = rem_i - {1'b0, div_i};
    assign q_o   = ~diff[XLEN];
    assign rem_o = q_o ? diff[XLEN-1:0] : rem_i[XLEN-1:0];

endmodule

// File: rtl/iter_div_unit.sv
// Iterative signed/unsigned divider with valid/allowin handshakes, flush,
// and single-cycle divide-by-zero / signed-overflow fast paths.
module iter_div_unit
    import iter_div_unit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int RADIX_BITS = 1,
    parameter int TAG_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_allowin,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_allowin,
    output logic [TAG_W-1:0] out_tag,
    output logic [XLEN-1:0]  out_data
);

    localparam int N     = div_iters(XLEN, RADIX_BITS);
    localparam int CNT_W = div_cnt_w(XLEN, RADIX_BITS);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t        state_q;
    div_op_t           op_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] rq_q;
    logic [XLEN-1:0]   b_q;
    logic              qneg_q;
    logic              rneg_q;
    logic              out_valid_q;
    logic [TAG_W-1:0]  out_tag_q;
    logic [XLEN-1:0]   out_data_q;

    div_op_t         in_op_e;
    logic            accept;
    logic            a_neg, b_neg, div0, ovf, fast;
    logic [XLEN-1:0] a_mag, b_mag, fast_res;
    logic [XLEN-1:0] quo, rem, fix_res;

    assign in_allowin = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_allowin);
    assign accept     = in_valid & in_allowin & ~flush;

    assign in_op_e  = div_op_t'(in_op);
    assign a_neg    = op_is_signed(in_op_e) & in_a[XLEN-1];
    assign b_neg    = op_is_signed(in_op_e) & in_b[XLEN-1];
    assign a_mag    = a_neg ? -in_a : in_a;
    assign b_mag    = b_neg ? -in_b : in_b;
    assign div0     = (in_b == '0);
    assign ovf      = op_is_signed(in_op_e) && (in_a == MIN_NEG) && (in_b == '1);
    assign fast     = div0 | ovf;
    assign fast_res = div0 ? (op_is_rem(in_op_e) ? in_a : '1)
                           : (op_is_rem(in_op_e) ? '0   : in_a);

    // Upper half holds the partial remainder, lower half the dividend being
    // shifted out while quotient bits shift in.
    logic [2*XLEN-1:0] chain [RADIX_BITS+1];
    assign chain[0] = rq_q;

    for (genvar k = 0; k < RADIX_BITS; k++) begin : g_step
        logic [XLEN-1:0] rem_nx;
        logic            qb;
        div_iter_step #(.XLEN(XLEN)) u_step (
            .rem_i (chain[k][2*XLEN-1:XLEN-1]),
            .div_i (b_q),
            .rem_o (rem_nx),
            .q_o   (qb)
        );
        assign chain[k+1] = {rem_nx, chain[k][XLEN-2:0], qb};
    end

    assign quo     = rq_q[XLEN-1:0];
    assign rem     = rq_q[2*XLEN-1:XLEN];
    assign fix_res = op_is_rem(op_q) ? (rneg_q ? -rem : rem)
                                     : (qneg_q ? -quo : quo);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_DIV;
            cnt_q       <= '0;
            rq_q        <= '0;
            b_q         <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
            out_data_q  <= '0;
        end else if (flush) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            op_q      <= in_op_e;
            out_tag_q <= in_tag;
            b_q       <= b_mag;
            rq_q      <= {{XLEN{1'b0}}, a_mag};
            qneg_q    <= a_neg ^ b_neg;
            rneg_q    <= a_neg;
            cnt_q     <= CNT_W'(N - 1);
            if (fast) begin
                out_data_q  <= fast_res;
                out_valid_q <= 1'b1;
                state_q     <= ST_DONE;
            end else begin
                out_valid_q <= 1'b0;
                state_q     <= ST_ITER;
            end
        end else begin
            case (state_q)
                ST_ITER: begin
                    rq_q  <= chain[RADIX_BITS];
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) state_q <= ST_FIX;
                end
                ST_FIX: begin
                    out_data_q  <= fix_res;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_allowin) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_tag   = out_tag_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_iter_div_unit.sv
// Bench for iter_div_unit: a default 32-bit/radix-2 instance and a 16-bit/radix-4
// instance, checked against an arithmetic reference model.
module tb_iter_div_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst32, fl32, iv32, ia32, ov32, oa32;
    logic [7:0]  it32, ot32;
    logic [31:0] a32, b32, od32;
    logic [1:0]  op32;

    logic        rst16, fl16, iv16, ia16, ov16, oa16;
    logic [7:0]  it16, ot16;
    logic [15:0] a16, b16, od16;
    logic [1:0]  op16;

    int total = 0;
    int bad   = 0;

    iter_div_unit u32 (
        .clk(clk), .rst(rst32), .flush(fl32),
        .in_valid(iv32), .in_allowin(ia32), .in_tag(it32),
        .in_a(a32), .in_b(b32), .in_op(op32),
        .out_valid(ov32), .out_allowin(oa32), .out_tag(ot32), .out_data(od32)
    );

    iter_div_unit #(.XLEN(16), .RADIX_BITS(2), .TAG_W(8)) u16 (
        .clk(clk), .rst(rst16), .flush(fl16),
        .in_valid(iv16), .in_allowin(ia16), .in_tag(it16),
        .in_a(a16), .in_b(b16), .in_op(op16),
        .out_valid(ov16), .out_allowin(oa16), .out_tag(ot16), .out_data(od16)
    );

    // Reference: plain integer division truncating toward zero, with the
    // divide-by-zero and signed-overflow conventions of the unit.
    task automatic ref_model(input int xlen, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, output logic [31:0] res, output int lat);
        longint one, m, ua, ub, sa, sb, q, r;
        logic   sgn;
        one = 1;
        m   = (one << xlen) - 1;
        ua  = longint'(a) & m;
        ub  = longint'(b) & m;
        sa  = ((ua >> (xlen - 1)) & 1) != 0 ? ua - (one << xlen) : ua;
        sb  = ((ub >> (xlen - 1)) & 1) != 0 ? ub - (one << xlen) : ub;
        sgn = (op == 2'd0) || (op == 2'd1);
        lat = xlen / ((xlen == 16) ? 2 : 1) + 2;
        if (ub == 0) begin
            q = -1; r = ua; lat = 1;
        end else if (sgn && sa == -(one << (xlen - 1)) && sb == -1) begin
            q = sa; r = 0; lat = 1;
        end else if (sgn) begin
            q = sa / sb; r = sa % sb;
        end else begin
            q = ua / ub; r = ua % ub;
        end
        res = 32'(((op == 2'd1 || op == 2'd3) ? r : q) & m);
    endtask

    task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] tag, output logic [31:0] d, output logic [7:0] t,
                         output int lat);
        oa32 = 1'b1; iv32 = 1'b1; op32 = op; a32 = a; b32 = b; it32 = tag;
        @(posedge clk); #1;
        iv32 = 1'b0; lat = 1;
        while (ov32 !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
        d = od32; t = ot32;
        @(posedge clk); #1;
    endtask

    task automatic run16(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [7:0] tag, output logic [15:0] d, output logic [7:0] t,
                         output int lat);
        oa16 = 1'b1; iv16 = 1'b1; op16 = op; a16 = a; b16 = b; it16 = tag;
        @(posedge clk); #1;
        iv16 = 1'b0; lat = 1;
        while (ov16 !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
        d = od16; t = ot16;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst32 = 1'b1; rst16 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (ov32 !== 1'b0)  begin bad++; $display("FAIL rst32_valid got=%b want=0", ov32); end
        total++; if (ia32 !== 1'b1)  begin bad++; $display("FAIL rst32_allowin got=%b want=1", ia32); end
        total++; if (ot32 !== 8'h00) begin bad++; $display("FAIL rst32_tag got=%h want=00", ot32); end
        total++; if (od32 !== 32'h0) begin bad++; $display("FAIL rst32_data got=%h want=0", od32); end
        total++; if (ov16 !== 1'b0)  begin bad++; $display("FAIL rst16_valid got=%b want=0", ov16); end
        total++; if (ia16 !== 1'b1)  begin bad++; $display("FAIL rst16_allowin got=%b want=1", ia16); end
        total++; if (od16 !== 16'h0) begin bad++; $display("FAIL rst16_data got=%h want=0", od16); end
        rst32 = 1'b0; rst16 = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [7:0]  lat;
    } vec_t;

    function automatic vec_t get_vec(input int i);
        case (i)
            0:  return '{2'd0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 8'd34};
            1:  return '{2'd1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 8'd34};
            2:  return '{2'd2, 32'hFFFFFFFF, 32'd3,        32'h55555555, 8'd34};
            3:  return '{2'd3, 32'd10,       32'd0,        32'd10,       8'd1};
            4:  return '{2'd2, 32'd10,       32'd0,        32'hFFFFFFFF, 8'd1};
            5:  return '{2'd0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 8'd1};
            6:  return '{2'd1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 8'd1};
            7:  return '{2'd0, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 8'd34};
            8:  return '{2'd1, 32'd100,      32'hFFFFFFF9, 32'd2,        8'd34};
            9:  return '{2'd2, 32'd0,        32'd5,        32'd0,        8'd34};
            10: return '{2'd0, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 8'd1};
            default: return '{2'd1, 32'hFFFFFFF9, 32'd0,   32'hFFFFFFF9, 8'd1};
        endcase
    endfunction

    task automatic test_directed32;
        logic [31:0] d;
        logic [7:0]  t, tag;
        int          lat;
        vec_t        v;
        for (int i = 0; i < 12; i++) begin
            v   = get_vec(i);
            tag = 8'(8'hA0 + i);
            run32(v.op, v.a, v.b, tag, d, t, lat);
            total++; if (d !== v.exp) begin bad++; $display("FAIL dir32_data[%0d] got=%h want=%h", i, d, v.exp); end
            total++; if (t !== tag) begin bad++; $display("FAIL dir32_tag[%0d] got=%h want=%h", i, t, tag); end
            total++; if (lat !== int'(v.lat)) begin bad++; $display("FAIL dir32_lat[%0d] got=%0d want=%0d", i, lat, v.lat); end
        end
    endtask

    task automatic test_random32;
        logic [31:0] a, b, d, e;
        logic [1:0]  op;
        logic [7:0]  t, tag;
        int          lat, el;
        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom_range(0, 3));
            a   = $urandom;
            b   = (i % 5 == 0) ? 32'($urandom_range(1, 9)) : $urandom >> $urandom_range(0, 31);
            tag = 8'($urandom);
            ref_model(32, op, a, b, e, el);
            run32(op, a, b, tag, d, t, lat);
            total++; if (d !== e || t !== tag || lat !== el) begin
                bad++; $display("FAIL rnd32 op=%0d a=%h b=%h got=%h/%h/%0d want=%h/%h/%0d", op, a, b, d, t, lat, e, tag, el);
            end
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        oa32 = 1'b0; iv32 = 1'b1; op32 = 2'd2; a32 = 32'd1000; b32 = 32'd7; it32 = 8'h11;
        @(posedge clk); #1;
        iv32 = 1'b0; lat = 1;
        while (ov32 !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
        total++; if (lat !== 34) begin bad++; $display("FAIL bp_lat got=%0d want=34", lat); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++; if (ov32 !== 1'b1 || od32 !== 32'd142 || ot32 !== 8'h11 || ia32 !== 1'b0) begin
                bad++; $display("FAIL bp_hold[%0d] got v=%b d=%h t=%h ia=%b want v=1 d=8e t=11 ia=0", i, ov32, od32, ot32, ia32);
            end
        end
        oa32 = 1'b1; iv32 = 1'b1; op32 = 2'd0; a32 = 32'hFFFFFF9C; b32 = 32'd7; it32 = 8'h22;
        #1;
        total++; if (ia32 !== 1'b1) begin bad++; $display("FAIL bp_release_allowin got=%b want=1", ia32); end
        @(posedge clk); #1;
        iv32 = 1'b0; lat = 1;
        total++; if (ov32 !== 1'b0) begin bad++; $display("FAIL bp_consumed got=%b want=0", ov32); end
        while (ov32 !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
        total++; if (lat !== 34 || od32 !== 32'hFFFFFFF2 || ot32 !== 8'h22) begin
            bad++; $display("FAIL b2b_result got lat=%0d d=%h t=%h want lat=34 d=fffffff2 t=22", lat, od32, ot32);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush;
        logic [31:0] d;
        logic [7:0]  t;
        int          lat, seen;
        oa32 = 1'b1; iv32 = 1'b1; op32 = 2'd2; a32 = 32'hFFFF0000; b32 = 32'd3; it32 = 8'h33;
        @(posedge clk); #1;
        iv32 = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        fl32 = 1'b1;
        @(posedge clk); #1;
        fl32 = 1'b0;
        total++; if (ov32 !== 1'b0 || ia32 !== 1'b1) begin
            bad++; $display("FAIL flush_iter got v=%b ia=%b want v=0 ia=1", ov32, ia32);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (ov32 === 1'b1) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL flush_no_result got=%0d want=0", seen); end
        run32(2'd2, 32'd100, 32'd7, 8'h44, d, t, lat);
        total++; if (d !== 32'd14 || t !== 8'h44 || lat !== 34) begin
            bad++; $display("FAIL flush_fresh got d=%h t=%h lat=%0d want d=e t=44 lat=34", d, t, lat);
        end
        oa32 = 1'b0; iv32 = 1'b1; op32 = 2'd2; a32 = 32'd50; b32 = 32'd5; it32 = 8'h55;
        @(posedge clk); #1;
        iv32 = 1'b0; lat = 1;
        while (ov32 !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
        total++; if (lat !== 34) begin bad++; $display("FAIL flush_done_lat got=%0d want=34", lat); end
        fl32 = 1'b1; oa32 = 1'b1;
        @(posedge clk); #1;
        fl32 = 1'b0;
        total++; if (ov32 !== 1'b0 || ia32 !== 1'b1) begin
            bad++; $display("FAIL flush_done got v=%b ia=%b want v=0 ia=1", ov32, ia32);
        end
        fl32 = 1'b1; iv32 = 1'b1; op32 = 2'd2; a32 = 32'd9; b32 = 32'd0; it32 = 8'h66;
        @(posedge clk); #1;
        fl32 = 1'b0; iv32 = 1'b0;
        total++; if (ov32 !== 1'b0) begin bad++; $display("FAIL flush_drop_input got=%b want=0", ov32); end
    endtask

    task automatic test_random16;
        logic [15:0] a, b, d;
        logic [31:0] e;
        logic [1:0]  op;
        logic [7:0]  t, tag;
        int          lat, el, sel;
        for (int i = 0; i < 1000; i++) begin
            op  = 2'($urandom_range(0, 3));
            a   = 16'($urandom);
            sel = $urandom_range(0, 9);
            if (sel == 0)      b = 16'h0;
            else if (sel == 1) begin b = 16'hFFFF; a = 16'h8000; end
            else if (sel < 4)  b = 16'($urandom_range(1, 7));
            else               b = 16'($urandom) >> $urandom_range(0, 15);
            tag = 8'($urandom);
            ref_model(16, op, {16'h0, a}, {16'h0, b}, e, el);
            run16(op, a, b, tag, d, t, lat);
            total++; if (d !== e[15:0] || t !== tag || lat !== el) begin
                bad++; $display("FAIL rnd16 op=%0d a=%h b=%h got=%h/%h/%0d want=%h/%h/%0d", op, a, b, d, t, lat, e[15:0], tag, el);
            end
        end
    endtask

    task automatic test_rst_mid16;
        logic [15:0] d;
        logic [7:0]  t;
        int          lat, seen;
        oa16 = 1'b1; iv16 = 1'b1; op16 = 2'd0; a16 = 16'h1234; b16 = 16'd5; it16 = 8'h77;
        @(posedge clk); #1;
        iv16 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst16 = 1'b1;
        @(posedge clk); #1;
        rst16 = 1'b0;
        total++; if (ov16 !== 1'b0 || ia16 !== 1'b1 || od16 !== 16'h0 || ot16 !== 8'h0) begin
            bad++; $display("FAIL rst_mid got v=%b ia=%b d=%h t=%h want 0/1/0/0", ov16, ia16, od16, ot16);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin @(posedge clk); #1; if (ov16 === 1'b1) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL rst_mid_no_result got=%0d want=0", seen); end
        run16(2'd2, 16'd100, 16'd7, 8'h88, d, t, lat);
        total++; if (d !== 16'd14 || t !== 8'h88 || lat !== 10) begin
            bad++; $display("FAIL rst_mid_fresh got d=%h t=%h lat=%0d want d=e t=88 lat=10", d, t, lat);
        end
    endtask

    initial begin
        rst32 = 1'b1; fl32 = 1'b0; iv32 = 1'b0; oa32 = 1'b1; it32 = '0; a32 = '0; b32 = '0; op32 = '0;
        rst16 = 1'b1; fl16 = 1'b0; iv16 = 1'b0; oa16 = 1'b1; it16 = '0; a16 = '0; b16 = '0; op16 = '0;
        test_reset();
        test_directed32();
        test_random32();
        test_back_to_back();
        test_flush();
        test_random16();
        test_rst_mid16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
